// File: rtl/hazard3_pwrup_responder.sv
// Always-on responder for the processor power-up req/ack handshake.
// Sequences fabric reset, clock gate, isolation and power switch on each request edge.
module hazard3_pwrup_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int PWR_SETTLE  = 16,
  parameter int CLK_SETTLE  = 4
) (
  input  logic clk_always_on,
  input  logic rst,
  input  logic pwrup_req,
  output logic pwrup_ack,
  input  logic pwr_good,
  output logic pwr_en,
  output logic iso_en,
  output logic fabric_clk_en,
  output logic fabric_rst_n,
  output logic busy
);

  // Handshake: 4-phase level protocol. The requester moves pwrup_req; we move
  // pwrup_ack to the same level only after the matching sequence has finished,
  // and never abort a sequence once started.

  typedef enum logic [2:0] {
    S_ON     = 3'd0,
    S_DN_RST = 3'd1,
    S_DN_CLK = 3'd2,
    S_DN_ISO = 3'd3,
    S_OFF    = 3'd4,
    S_UP_PWR = 3'd5,
    S_UP_CLK = 3'd6
  } state_t;

  localparam logic [7:0] PWR_LOAD = 8'(PWR_SETTLE - 1);
  localparam logic [7:0] CLK_LOAD = 8'(CLK_SETTLE - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       req_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = pwrup_req;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // Reset to 1 so a powered-up reset state does not see a phantom request drop.
      always_ff @(posedge clk_always_on) begin
        if (rst) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= pwrup_req;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign req_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk_always_on) begin
    if (rst) begin
      state         <= S_ON;
      cnt           <= 8'd0;
      pwrup_ack     <= 1'b1;
      pwr_en        <= 1'b1;
      iso_en        <= 1'b0;
      fabric_clk_en <= 1'b1;
      fabric_rst_n  <= 1'b1;
      busy          <= 1'b0;
    end else begin
      case (state)
        S_ON: begin
          if (!req_s) begin
            fabric_rst_n <= 1'b0;
            cnt          <= CLK_LOAD;
            state        <= S_DN_RST;
            busy         <= 1'b1;
          end
        end
        S_DN_RST: begin
          if (cnt == 8'd0) begin
            fabric_clk_en <= 1'b0;
            cnt           <= CLK_LOAD;
            state         <= S_DN_CLK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_DN_CLK: begin
          if (cnt == 8'd0) begin
            iso_en <= 1'b1;
            state  <= S_DN_ISO;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_DN_ISO: begin
          pwr_en    <= 1'b0;
          pwrup_ack <= 1'b0;
          state     <= S_OFF;
          busy      <= 1'b0;
        end
        S_OFF: begin
          if (req_s) begin
            pwr_en <= 1'b1;
            cnt    <= PWR_LOAD;
            state  <= S_UP_PWR;
            busy   <= 1'b1;
          end
        end
        S_UP_PWR: begin
          // Settle time elapsed: wait indefinitely for the rail to report good.
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (pwr_good) begin
            iso_en        <= 1'b0;
            fabric_clk_en <= 1'b1;
            cnt           <= CLK_LOAD;
            state         <= S_UP_CLK;
          end
        end
        S_UP_CLK: begin
          if (cnt == 8'd0) begin
            fabric_rst_n <= 1'b1;
            pwrup_ack    <= 1'b1;
            state        <= S_ON;
            busy         <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= S_ON;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard3_pwrup_responder.sv
// Bench for hazard3_pwrup_responder: default instance plus a fast unsynchronised one,
// both compared every cycle against a timeline model of the handshake.
module tb_hazard3_pwrup_responder;

  logic clk = 1'b0;
  logic rst;
  logic req, good, req0, good0;
  logic ack, pwr, iso, clk_en, frst_n, busy;
  logic ack0, pwr0, iso0, clk_en0, frst_n0, busy0;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hazard3_pwrup_responder dut (
    .clk_always_on(clk), .rst(rst), .pwrup_req(req), .pwrup_ack(ack),
    .pwr_good(good), .pwr_en(pwr), .iso_en(iso), .fabric_clk_en(clk_en),
    .fabric_rst_n(frst_n), .busy(busy)
  );

  hazard3_pwrup_responder #(.SYNC_STAGES(0), .PWR_SETTLE(3), .CLK_SETTLE(1)) dut0 (
    .clk_always_on(clk), .rst(rst), .pwrup_req(req0), .pwrup_ack(ack0),
    .pwr_good(good0), .pwr_en(pwr0), .iso_en(iso0), .fabric_clk_en(clk_en0),
    .fabric_rst_n(frst_n0), .busy(busy0)
  );

  // ---------------- behavioural model ----------------
  // A sequence is described by its direction and the number of edges since it
  // started; output levels follow from that offset by plain arithmetic.
  typedef struct {
    bit [3:0] hist;
    bit       level;
    bit       active;
    bit       dir_up;
    int       t;
    int       g;
  } mst_t;

  function automatic mst_t mreset();
    mst_t n;
    n.hist = 4'hF; n.level = 1'b1; n.active = 1'b0; n.dir_up = 1'b0; n.t = 0; n.g = -1;
    return n;
  endfunction

  function automatic mst_t mstep(mst_t s, logic r, logic q, logic g, int sync, int p, int c);
    mst_t n = s;
    logic rs;
    if (r) return mreset();
    rs = (sync == 0) ? q : s.hist[sync-1];
    n.hist = {s.hist[2:0], q};
    if (!s.active) begin
      if (s.level && !rs) begin
        n.active = 1'b1; n.dir_up = 1'b0; n.t = 0;
      end else if (!s.level && rs) begin
        n.active = 1'b1; n.dir_up = 1'b1; n.t = 0; n.g = -1;
      end
    end else begin
      n.t = s.t + 1;
      if (!s.dir_up) begin
        if (n.t == 2*c + 1) begin n.active = 1'b0; n.level = 1'b0; end
      end else begin
        if (s.g < 0 && n.t >= p && g) n.g = n.t;
        if (n.g >= 0 && n.t == n.g + c) begin n.active = 1'b0; n.level = 1'b1; end
      end
    end
    return n;
  endfunction

  // {ack, pwr_en, iso_en, fabric_clk_en, fabric_rst_n, busy}
  function automatic logic [5:0] mout(mst_t s, int c);
    logic clk_on;
    if (!s.active) return s.level ? 6'b110110 : 6'b001000;
    if (!s.dir_up) return {1'b1, 1'b1, (s.t >= 2*c), (s.t < c), 1'b0, 1'b1};
    clk_on = (s.g >= 0) && (s.t >= s.g);
    return {1'b0, 1'b1, !clk_on, clk_on, 1'b0, 1'b1};
  endfunction

  mst_t ms_a = mreset();
  mst_t ms_b = mreset();
  bit   m_valid = 1'b0;
  logic [5:0] exp_qa[$];
  logic [5:0] exp_qb[$];

  always @(posedge clk) begin
    if (rst || m_valid) begin
      exp_qa.push_back(mout(mstep(ms_a, rst, req, good, 2, 16, 4), 4));
      exp_qb.push_back(mout(mstep(ms_b, rst, req0, good0, 0, 3, 1), 1));
      ms_a    <= mstep(ms_a, rst, req, good, 2, 16, 4);
      ms_b    <= mstep(ms_b, rst, req0, good0, 0, 3, 1);
      m_valid <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [5:0] e, a;
    if (exp_qa.size() > 0) begin
      e = exp_qa.pop_front();
      a = {ack, pwr, iso, clk_en, frst_n, busy};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL model_dut t=%0t outputs got=%b exp=%b", $time, a, e);
      end
    end
    if (exp_qb.size() > 0) begin
      e = exp_qb.pop_front();
      a = {ack0, pwr0, iso0, clk_en0, frst_n0, busy0};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL model_dut0 t=%0t outputs got=%b exp=%b", $time, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b1; good = 1'b1; req0 = 1'b1; good0 = 1'b1;

    // Reset held 3 cycles, then ack must stay high with req high.
    step(3);
    rst = 1'b0;
    chk("rst_ack", ack, 1'b1);    chk("rst_pwr", pwr, 1'b1);
    chk("rst_iso", iso, 1'b0);    chk("rst_clk", clk_en, 1'b1);
    chk("rst_frst", frst_n, 1'b1); chk("rst_busy", busy, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("rst_ack_hold", ack, 1'b1);
    end

    // Power-down with defaults: edges 2 / 6 / 10 / 11.
    req = 1'b0;
    step(2);  chk("dn_frst_e1", frst_n, 1'b1);
    step(1);  chk("dn_frst_e2", frst_n, 1'b0); chk("dn_busy_e2", busy, 1'b1);
    step(3);  chk("dn_clk_e5", clk_en, 1'b1);
    step(1);  chk("dn_clk_e6", clk_en, 1'b0);
    step(3);  chk("dn_iso_e9", iso, 1'b0);
    step(1);  chk("dn_iso_e10", iso, 1'b1); chk("dn_pwr_e10", pwr, 1'b1);
    step(1);  chk("dn_pwr_e11", pwr, 1'b0); chk("dn_ack_e11", ack, 1'b0);
    chk("dn_busy_e11", busy, 1'b0);
    step(3);

    // Power-up with defaults: edges 2 / 18 / 22.
    req = 1'b1;
    step(2);  chk("up_pwr_e1", pwr, 1'b0);
    step(1);  chk("up_pwr_e2", pwr, 1'b1); chk("up_busy_e2", busy, 1'b1);
    step(15); chk("up_clk_e17", clk_en, 1'b0); chk("up_iso_e17", iso, 1'b1);
    step(1);  chk("up_clk_e18", clk_en, 1'b1); chk("up_iso_e18", iso, 1'b0);
    step(3);  chk("up_ack_e21", ack, 1'b0); chk("up_frst_e21", frst_n, 1'b0);
    step(1);  chk("up_ack_e22", ack, 1'b1); chk("up_frst_e22", frst_n, 1'b1);
    chk("up_busy_e22", busy, 1'b0);
    step(3);

    // Late pwr_good: held low until edge 40.
    req = 1'b0;
    step(20);
    good = 1'b0; req = 1'b1;
    step(40); chk("late_iso_e39", iso, 1'b1); chk("late_clk_e39", clk_en, 1'b0);
    chk("late_busy_e39", busy, 1'b1);
    good = 1'b1;
    step(1);  chk("late_clk_e40", clk_en, 1'b1); chk("late_iso_e40", iso, 1'b0);
    step(3);  chk("late_ack_e43", ack, 1'b0);
    step(1);  chk("late_ack_e44", ack, 1'b1);
    step(3);

    // Reset while in the clock-off step of power-down.
    req = 1'b0;
    step(8);  chk("mrst_clk_pre", clk_en, 1'b0); chk("mrst_iso_pre", iso, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0; req = 1'b1;
    chk("mrst_clk", clk_en, 1'b1); chk("mrst_frst", frst_n, 1'b1);
    chk("mrst_ack", ack, 1'b1);    chk("mrst_busy", busy, 1'b0);
    step(3);

    // Request reversal on the unsynchronised, C=1, P=3 instance.
    req0 = 1'b0;
    step(1);  chk("rev_frst_e0", frst_n0, 1'b0);
    req0 = 1'b1;
    step(2);  chk("rev_ack_e2", ack0, 1'b1); chk("rev_iso_e2", iso0, 1'b1);
    step(1);  chk("rev_ack_e3", ack0, 1'b0); chk("rev_pwr_e3", pwr0, 1'b0);
    step(1);  chk("rev_pwr_e4", pwr0, 1'b1); chk("rev_busy_e4", busy0, 1'b1);
    step(3);  chk("rev_clk_e7", clk_en0, 1'b1);
    step(1);  chk("rev_ack_e8", ack0, 1'b1);
    step(2);

    // Randomised traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) req = ~req;
      if ($urandom_range(0, 19) == 0) req0 = ~req0;
      if (good) begin if ($urandom_range(0, 29) == 0) good = 1'b0; end
      else begin if ($urandom_range(0, 7) == 0) good = 1'b1; end
      if (good0) begin if ($urandom_range(0, 9) == 0) good0 = 1'b0; end
      else begin if ($urandom_range(0, 3) == 0) good0 = 1'b1; end
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0; good = 1'b1; good0 = 1'b1;
    step(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
